// File: rtl/vector_dot_product_pipelined_acc_param_if.sv
// Beat-in / result-out bundle for the pipelined dot-product engine.
// The master drives beats and accepts results; the slave is the engine.
interface vector_dot_product_pipelined_acc_param_if #(
    parameter int N      = 8,
    parameter int W      = 8,
    parameter int OW     = 27,
    parameter int BEAT_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0][W-1:0] vec_a;
    logic [N-1:0][W-1:0] vec_b;
    logic                in_last;
    logic [OW-1:0]       dot_product;
    logic [BEAT_W-1:0]   beats;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_valid, vec_a, vec_b, in_last, out_ready,
        input  in_ready, dot_product, beats, out_valid
    );

    modport slave (
        input  in_valid, vec_a, vec_b, in_last, out_ready,
        output in_ready, dot_product, beats, out_valid
    );
endinterface

// File: rtl/vector_dot_product_pipelined_acc_param.sv
// Pipelined N-element dot product with multi-beat accumulation up to in_last.
// Latency: product reg, LOG2N adder-tree regs, accumulator reg (LOG2N+2 registers).
// Backpressure: a held result with out_ready low freezes the whole pipe; in_ready = !stall.
module vector_dot_product_pipelined_acc_param #(
    parameter int N      = 8,
    parameter int W      = 8,
    parameter int SIGNED = 0,
    parameter int ACC_X  = 8,
    parameter int BEAT_W = 8
) (
    input logic clk,
    input logic rst_n,
    vector_dot_product_pipelined_acc_param_if.slave bus
);
    localparam int LOG2N = $clog2(N);
    localparam int TW    = 2 * W + LOG2N;
    localparam int OW    = TW + ACC_X;

    logic stall;

    logic [2*W-1:0] ax [N];
    logic [2*W-1:0] bx [N];
    logic [2*W-1:0] pr [N];
    logic [TW-1:0]  prod_ext [N];

    // lvl[0] is the product stage, lvl[k] holds the N>>k partial sums of tree level k
    logic [TW-1:0]  lvl [LOG2N+1][N];
    logic [LOG2N:0] v_q;
    logic [LOG2N:0] l_q;

    logic [TW-1:0]     tree_out;
    logic [OW-1:0]     tree_ext;
    logic [OW-1:0]     sum;
    logic [OW-1:0]     acc_q;
    logic [BEAT_W-1:0] cnt_q;
    logic [BEAT_W-1:0] cnt_nxt;
    logic              first_q;
    logic [OW-1:0]     dot_q;
    logic [BEAT_W-1:0] beats_q;
    logic              ov_q;

    assign stall        = ov_q && !bus.out_ready;
    assign bus.in_ready = !stall;

    // Operands are pre-extended to 2W so one unsigned multiply serves both modes
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ax[i]       = {{W{(SIGNED != 0) && bus.vec_a[i][W-1]}}, bus.vec_a[i]};
            bx[i]       = {{W{(SIGNED != 0) && bus.vec_b[i][W-1]}}, bus.vec_b[i]};
            pr[i]       = ax[i] * bx[i];
            prod_ext[i] = {{LOG2N{(SIGNED != 0) && pr[i][2*W-1]}}, pr[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            l_q <= '0;
            for (int k = 0; k <= LOG2N; k++) begin
                for (int j = 0; j < N; j++) begin
                    lvl[k][j] <= '0;
                end
            end
        end else if (!stall) begin
            v_q[0] <= bus.in_valid;
            l_q[0] <= bus.in_last;
            for (int i = 0; i < N; i++) begin
                lvl[0][i] <= prod_ext[i];
            end
            for (int k = 1; k <= LOG2N; k++) begin
                v_q[k] <= v_q[k-1];
                l_q[k] <= l_q[k-1];
                for (int j = 0; j < N / 2; j++) begin
                    if (j < (N >> k)) begin
                        lvl[k][j] <= lvl[k-1][2*j] + lvl[k-1][2*j+1];
                    end
                end
            end
        end
    end

    assign tree_out = lvl[LOG2N][0];

    generate
        if (SIGNED != 0) begin : g_ext_s
            assign tree_ext = OW'($signed(tree_out));
        end else begin : g_ext_u
            assign tree_ext = OW'(tree_out);
        end
    endgenerate

    assign sum     = (first_q ? '0 : acc_q) + tree_ext;
    assign cnt_nxt = first_q ? BEAT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);

    // A new closing beat overwrites the result on the same edge the old one retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            dot_q   <= '0;
            beats_q <= '0;
            ov_q    <= 1'b0;
        end else if (!stall) begin
            ov_q <= v_q[LOG2N] && l_q[LOG2N];
            if (v_q[LOG2N]) begin
                if (l_q[LOG2N]) begin
                    dot_q   <= sum;
                    beats_q <= cnt_nxt;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    first_q <= 1'b1;
                end else begin
                    acc_q   <= sum;
                    cnt_q   <= cnt_nxt;
                    first_q <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid   = ov_q;
    assign bus.dot_product = dot_q;
    assign bus.beats       = beats_q;
endmodule

// File: tb/tb_vector_dot_product_pipelined_acc_param.sv
// Scoreboard bench: three engine configurations (unsigned 8x8, signed 8x8, unsigned 4x4 no headroom).
module tb_vector_dot_product_pipelined_acc_param;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    localparam int OW8 = 27;
    localparam int OW4 = 10;

    vector_dot_product_pipelined_acc_param_if #(.N(8), .W(8), .OW(OW8), .BEAT_W(8)) bu ();
    vector_dot_product_pipelined_acc_param_if #(.N(8), .W(8), .OW(OW8), .BEAT_W(8)) bs ();
    vector_dot_product_pipelined_acc_param_if #(.N(4), .W(4), .OW(OW4), .BEAT_W(8)) b4 ();

    vector_dot_product_pipelined_acc_param #(.N(8), .W(8), .SIGNED(0), .ACC_X(8), .BEAT_W(8))
        u_u8 (.clk(clk), .rst_n(rst_n), .bus(bu));
    vector_dot_product_pipelined_acc_param #(.N(8), .W(8), .SIGNED(1), .ACC_X(8), .BEAT_W(8))
        u_s8 (.clk(clk), .rst_n(rst_n), .bus(bs));
    vector_dot_product_pipelined_acc_param #(.N(4), .W(4), .SIGNED(0), .ACC_X(0), .BEAT_W(8))
        u_n4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    typedef struct {
        logic [63:0] dot;
        int          beats;
    } exp_t;

    exp_t q_u[$];
    exp_t q_s[$];
    exp_t q_4[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t1_acc   = -1;
    bit toggle_en = 1'b0;

    localparam logic [63:0] M27 = (64'd1 << OW8) - 64'd1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0][7:0] fill8(input int v);
        logic [7:0][7:0] r;
        for (int i = 0; i < 8; i++) r[i] = 8'(v);
        return r;
    endfunction

    function automatic logic [3:0][3:0] fill4(input int v);
        logic [3:0][3:0] r;
        for (int i = 0; i < 4; i++) r[i] = 4'(v);
        return r;
    endfunction

    // Result sinks: pop one expectation per accepted result
    always @(negedge clk) begin : mon_u
        exp_t e;
        chk("u_in_ready", 64'(bu.in_ready), 64'(!(bu.out_valid && !bu.out_ready)));
        if (bu.out_valid && bu.out_ready) begin
            if (q_u.size() == 0) begin
                checks++; failures++;
                $display("FAIL u_unexpected got dot=%0d want no result", bu.dot_product);
            end else begin
                e = q_u.pop_front();
                chk("u_dot", 64'(bu.dot_product), e.dot);
                chk("u_beats", 64'(bu.beats), 64'(e.beats));
                if (t1_acc >= 0) begin
                    chk("u_latency", 64'(cyc - t1_acc), 64'd4);
                    t1_acc = -1;
                end
            end
        end
    end

    always @(negedge clk) begin : mon_s
        exp_t e;
        if (bs.out_valid && bs.out_ready) begin
            if (q_s.size() == 0) begin
                checks++; failures++;
                $display("FAIL s_unexpected got dot=%0d want no result", bs.dot_product);
            end else begin
                e = q_s.pop_front();
                chk("s_dot", 64'(bs.dot_product), e.dot);
                chk("s_beats", 64'(bs.beats), 64'(e.beats));
            end
        end
    end

    always @(negedge clk) begin : mon_4
        exp_t e;
        if (b4.out_valid && b4.out_ready) begin
            if (q_4.size() == 0) begin
                checks++; failures++;
                $display("FAIL n4_unexpected got dot=%0d want no result", b4.dot_product);
            end else begin
                e = q_4.pop_front();
                chk("n4_dot", 64'(b4.dot_product), e.dot);
                chk("n4_beats", 64'(b4.beats), 64'(e.beats));
            end
        end
    end

    // out_ready pattern for the unsigned engine: 1,0,0 repeating while toggling
    initial begin : rdy_u
        int ph = 0;
        bu.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bu.out_ready = toggle_en ? (ph % 3 == 0) : 1'b1;
            ph++;
        end
    end

    task automatic send_u(input logic [7:0][7:0] a, input logic [7:0][7:0] b, input logic last,
                          input bit mark);
        int n = 0;
        @(negedge clk);
        bu.vec_a = a; bu.vec_b = b; bu.in_last = last; bu.in_valid = 1'b1;
        while (!bu.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bu.in_ready) begin
            checks++; failures++;
            $display("FAIL u_send_timeout got in_ready=0 want 1");
        end
        @(posedge clk);
        #1;
        if (mark) t1_acc = cyc;
        bu.in_valid = 1'b0;
    endtask

    task automatic send_s(input logic [7:0][7:0] a, input logic [7:0][7:0] b, input logic last);
        @(negedge clk);
        chk("s_in_ready", 64'(bs.in_ready), 64'd1);
        bs.vec_a = a; bs.vec_b = b; bs.in_last = last; bs.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bs.in_valid = 1'b0;
    endtask

    task automatic send_4(input logic [3:0][3:0] a, input logic [3:0][3:0] b, input logic last);
        @(negedge clk);
        chk("n4_in_ready", 64'(b4.in_ready), 64'd1);
        b4.vec_a = a; b4.vec_b = b; b4.in_last = last; b4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        b4.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && (q_u.size() + q_s.size() + q_4.size()) != 0; n++) @(negedge clk);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0][7:0] va;
        logic [7:0][7:0] vb;
        rst_n = 1'b0;
        bu.in_valid = 1'b0; bu.in_last = 1'b0; bu.vec_a = '0; bu.vec_b = '0;
        bs.in_valid = 1'b0; bs.in_last = 1'b0; bs.vec_a = '0; bs.vec_b = '0; bs.out_ready = 1'b1;
        b4.in_valid = 1'b0; b4.in_last = 1'b0; b4.vec_a = '0; b4.vec_b = '0; b4.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bu.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bu.in_ready), 64'd1);
        chk("rst_dot", 64'(bu.dot_product), 64'd0);
        chk("rst_beats", 64'(bu.beats), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_out_valid", 64'(bu.out_valid), 64'd0);

        // all-ones single beat, with latency and one-cycle valid
        q_u.push_back('{64'd520200, 1});
        send_u(fill8(255), fill8(255), 1'b1, 1'b1);
        drain();
        @(negedge clk);
        chk("t1_one_cycle", 64'(bu.out_valid), 64'd0);

        // three back-to-back beats of {1..8}.{1 x8}
        for (int i = 0; i < 8; i++) va[i] = 8'(i + 1);
        q_u.push_back('{64'd108, 3});
        send_u(va, fill8(1), 1'b0, 1'b0);
        send_u(va, fill8(1), 1'b0, 1'b0);
        send_u(va, fill8(1), 1'b1, 1'b0);
        drain();

        // partial sum persists across bubbles
        q_u.push_back('{64'd16, 2});
        send_u(fill8(1), fill8(1), 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        send_u(fill8(1), fill8(1), 1'b1, 1'b0);
        drain();

        // streamed single beats under a 1,0,0 out_ready pattern
        toggle_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            q_u.push_back('{64'(8 * k * k), 1});
            send_u(fill8(k), fill8(k), 1'b1, 1'b0);
        end
        for (int i = 0; i < 8; i++) vb[i] = 8'(8 - i);
        q_u.push_back('{64'd120, 1});
        send_u(va, vb, 1'b1, 1'b0);
        drain();
        toggle_en = 1'b0;
        repeat (2) @(negedge clk);

        // reset mid-accumulation discards the partial result
        send_u(fill8(3), fill8(3), 1'b0, 1'b0);
        send_u(fill8(3), fill8(3), 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_no_valid", 64'(bu.out_valid), 64'd0);
        q_u.push_back('{64'd32, 1});
        send_u(fill8(2), fill8(2), 1'b1, 1'b0);
        drain();

        // signed mode
        q_s.push_back('{M27 & 64'(-130048), 1});
        send_s(fill8(-128), fill8(127), 1'b1);
        for (int i = 0; i < 8; i++) va[i] = 8'((i % 2 == 0) ? (i + 1) : -(i + 1));
        q_s.push_back('{M27 & 64'(-4), 1});
        send_s(va, fill8(1), 1'b1);
        q_s.push_back('{64'd16, 2});
        send_s(fill8(-1), fill8(-1), 1'b0);
        send_s(fill8(-1), fill8(-1), 1'b1);
        drain();

        // 4x4 engine with no headroom: accumulator wraps mod 2^10
        q_4.push_back('{64'd776, 2});
        send_4(fill4(15), fill4(15), 1'b0);
        send_4(fill4(15), fill4(15), 1'b1);
        drain();

        repeat (4) @(negedge clk);
        chk("u_queue_empty", 64'(q_u.size()), 64'd0);
        chk("s_queue_empty", 64'(q_s.size()), 64'd0);
        chk("n4_queue_empty", 64'(q_4.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
